// File: rtl/uart_byte_tx.sv
// 8N1 UART byte transmitter with rising-edge send request and a one-cycle done strobe.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop (8E1).
module uart_byte_tx #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       send_en,
    input  logic [7:0] tx_data,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       uart_txd
);

    localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
    localparam int CW       = $clog2(BAUD_DIV + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    state_t        state, state_nxt;
    logic          send_en_d;
    logic [CW-1:0] baud_cnt, cnt_nxt;
    logic [2:0]    bit_idx, idx_nxt;
    logic [7:0]    shift_reg, shift_nxt;
    logic          txd_nxt, busy_nxt, done_nxt;
    logic          start_edge, bit_end;
`ifdef UART_TX_PARITY_EN
    logic          parity_bit, parity_nxt;
`endif

    assign start_edge = send_en & ~send_en_d;
    assign bit_end    = (baud_cnt == CNT_LAST);

    // All outputs are registered; uart_txd resets high asynchronously to abort a frame cleanly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            send_en_d  <= 1'b0;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            uart_txd   <= 1'b1;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            state      <= state_nxt;
            send_en_d  <= send_en;
            baud_cnt   <= cnt_nxt;
            bit_idx    <= idx_nxt;
            shift_reg  <= shift_nxt;
            uart_txd   <= txd_nxt;
            tx_busy    <= busy_nxt;
            tx_done    <= done_nxt;
`ifdef UART_TX_PARITY_EN
            parity_bit <= parity_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = bit_end ? '0 : baud_cnt + 1'b1;
        idx_nxt    = bit_idx;
        shift_nxt  = shift_reg;
        txd_nxt    = uart_txd;
        done_nxt   = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_nxt = parity_bit;
`endif
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                txd_nxt = 1'b1;
                if (start_edge) begin
                    state_nxt  = START;
                    shift_nxt  = tx_data;
                    txd_nxt    = 1'b0;
`ifdef UART_TX_PARITY_EN
                    parity_nxt = ^tx_data;
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    state_nxt = DATA;
                    idx_nxt   = '0;
                    txd_nxt   = shift_reg[0];
                end
            end
            DATA: begin
                // LSB is always at shift_reg[0]; the next bit is staged from shift_reg[1].
                if (bit_end) begin
                    if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_nxt = PARITY;
                        txd_nxt   = parity_bit;
`else
                        state_nxt = STOP;
                        txd_nxt   = 1'b1;
`endif
                    end else begin
                        idx_nxt   = bit_idx + 3'd1;
                        shift_nxt = {1'b0, shift_reg[7:1]};
                        txd_nxt   = shift_reg[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_nxt = STOP;
                    txd_nxt   = 1'b1;
                end
            end
`endif
            STOP: begin
                txd_nxt = 1'b1;
                if (bit_end) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                txd_nxt   = 1'b1;
            end
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

endmodule

// File: tb/tb_uart_byte_tx.sv
// Scoreboard bench for uart_byte_tx: stimulus queues expected bytes, a line monitor
// captures every busy window, decodes the frame and checks bit values and timing.
module tb_uart_byte_tx;

    localparam int DIV = 434;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME = 11;
`else
    localparam int FRAME = 10;
`endif
    localparam int WAIT_MAX = 6000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       send_en = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_busy, tx_done, uart_txd;

    uart_byte_tx dut (
        .clk(clk), .rst_n(rst_n), .send_en(send_en), .tx_data(tx_data),
        .tx_busy(tx_busy), .tx_done(tx_done), .uart_txd(uart_txd)
    );

    always #5 clk = ~clk;

    int         tests = 0;
    int         fails = 0;
    int         frames = 0;
    int         dones = 0;
    logic [7:0] exp_q[$];
    logic       smp[0:WAIT_MAX];
    int         nsamp = 0;
    bit         in_frame = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic end_frame();
        logic [10:0] ev, ov;
        logic [7:0]  b;
        bit          uni;
        frames++;
        check("done_at_busy_fall", tx_done, 1);
        check("busy_len", nsamp, FRAME * DIV);
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_frame: got frame %0d expected none", frames);
            return;
        end
        b  = exp_q.pop_front();
        ev = '0;
        for (int i = 0; i < 8; i++) ev[i+1] = b[i];
`ifdef UART_TX_PARITY_EN
        ev[9] = ^b;
`endif
        ev[FRAME-1] = 1'b1;
        ov  = '0;
        uni = 1'b1;
        for (int k = 0; k < FRAME; k++) begin
            ov[k] = smp[k*DIV + DIV/2];
            for (int j = 0; j < DIV; j++)
                if (smp[k*DIV + j] !== smp[k*DIV]) uni = 1'b0;
        end
        check("frame_bits", ov, ev);
        check("bit_uniform", uni, 1);
    endtask

    // Line monitor: a frame is the busy window; reset mid-frame drops the queued byte.
    always @(negedge clk) begin
        if (tx_done === 1'b1) dones++;
        if (!rst_n) begin
            if (in_frame && exp_q.size() > 0) void'(exp_q.pop_front());
            in_frame = 1'b0;
            nsamp    = 0;
        end else if (tx_busy === 1'b1) begin
            in_frame = 1'b1;
            if (nsamp <= WAIT_MAX) smp[nsamp] = uart_txd;
            nsamp++;
        end else if (in_frame) begin
            in_frame = 1'b0;
            end_frame();
            nsamp = 0;
        end
    end

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        tx_data = b;
        send_en = 1'b1;
        exp_q.push_back(b);
        @(negedge clk);
        send_en = 1'b0;
        tx_data = ~b;
        check("busy_rise", tx_busy, 1);
        check("start_bit", uart_txd, 0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (tx_busy === 1'b1 && n < WAIT_MAX) begin
            @(negedge clk);
            n++;
        end
        if (n >= WAIT_MAX) begin
            tests++;
            fails++;
            $display("FAIL wait_idle_timeout: got %0d cycles expected < %0d", n, WAIT_MAX);
        end
    endtask

    logic [7:0] bb[3] = '{8'h00, 8'hFF, 8'h3C};

    initial begin
        repeat (3) @(negedge clk);
        check("rst_txd", uart_txd, 1);
        check("rst_busy", tx_busy, 0);
        check("rst_done", tx_done, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        send(8'hA5); wait_idle();
        send(8'h07); wait_idle();
        send(8'h03); wait_idle();

        // Edge during busy is dropped; the still-high level must not retrigger.
        send(8'h5A);
        repeat (1000) @(negedge clk);
        tx_data = 8'hC3;
        send_en = 1'b1;
        wait_idle();
        repeat (300) @(negedge clk);
        check("ignored_busy", tx_busy, 0);
        check("ignored_txd", uart_txd, 1);
        send_en = 1'b0;
        repeat (5) @(negedge clk);

        // Back-to-back: re-raise send_en in the first busy-low cycle.
        for (int i = 0; i < 3; i++) begin
            tx_data = bb[i];
            send_en = 1'b1;
            exp_q.push_back(bb[i]);
            @(negedge clk);
            send_en = 1'b0;
            tx_data = ~bb[i];
            check("b2b_restart", tx_busy, 1);
            wait_idle();
        end
        repeat (5) @(negedge clk);

        // Reset during DATA bit 4 aborts the frame asynchronously.
        send(8'h96);
        repeat (5*DIV + 200) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_txd", uart_txd, 1);
        check("abort_busy", tx_busy, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("post_abort_txd", uart_txd, 1);
        check("post_abort_busy", tx_busy, 0);
        send(8'hC3); wait_idle();

        // send_en high across reset release counts as one edge.
        @(negedge clk);
        rst_n   = 1'b0;
        send_en = 1'b1;
        tx_data = 8'hE1;
        exp_q.push_back(8'hE1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_busy", tx_busy, 1);
        wait_idle();
        repeat (300) @(negedge clk);
        check("rel_no_retrigger", tx_busy, 0);
        check("rel_txd", uart_txd, 1);
        send_en = 1'b0;

        repeat (10) @(negedge clk);
        check("frame_count", frames, 9);
        check("done_count", dones, 9);
        check("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
